// File: rtl/wb_regfile.sv
// RV32I write-back stage: MEM/WB result latch, 32-entry integer register file,
// two combinational read ports with bypass of the latched (pending) write.
module wb_regfile #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [4:0]        raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [4:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [31:0]       commit_cnt_o
);

  logic [DATA_W-1:0] regs [REG_NUM];
  logic              commit;

  assign commit = wb_wreg_o && (wb_wd_o != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (flush_i || stall_i) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else begin
      wb_wd_o    <= wd_i;
      wb_wreg_o  <= wreg_i;
      wb_wdata_o <= wdata_i;
    end
  end

  // The latched result retires regardless of stall/flush; reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs         <= '{default: '0};
      commit_cnt_o <= '0;
    end else if (commit) begin
      regs[wb_wd_o] <= wb_wdata_o;
      commit_cnt_o  <= commit_cnt_o + 32'd1;
    end
  end

  always_comb begin
    rdata1_o = '0;
    if (!rst && re1_i && (raddr1_i != '0)) begin
      if (wb_wreg_o && (wb_wd_o == raddr1_i))
        rdata1_o = wb_wdata_o;
      else
        rdata1_o = regs[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (!rst && re2_i && (raddr2_i != '0)) begin
      if (wb_wreg_o && (wb_wd_o == raddr2_i))
        rdata2_o = wb_wdata_o;
      else
        rdata2_o = regs[raddr2_i];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// against an architectural-view model (latest-value array, commit counter).
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] wdata;
  logic        stall;
  logic        flush;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] commit_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: arch[] is what a reader should see (includes the pending write),
  // m_cnt counts retired writes, m_pend marks a latched write not yet retired.
  logic [31:0] arch [32];
  logic [31:0] m_cnt;
  logic        m_pend;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  wb_regfile #(.REG_NUM(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
    .stall_i(stall), .flush_i(flush),
    .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1),
    .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(rdata2),
    .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata),
    .commit_cnt_o(commit_cnt)
  );

  function automatic logic [31:0] expect_read(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
    return arch[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) arch[i] = 32'd0;
      m_cnt = 32'd0; m_pend = 1'b0;
      m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0;
    end else begin
      if (m_pend) m_cnt = m_cnt + 32'd1;
      if (stall || flush) begin
        m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0;
      end else begin
        m_wd = wd; m_wreg = wreg; m_wdata = wdata;
      end
      m_pend = m_wreg && (m_wd != 5'd0);
      if (m_pend) arch[m_wd] = m_wdata;
    end
    #1;
  endtask

  task automatic idle();
    wd = 5'd0; wreg = 1'b0; wdata = 32'd0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
    tick(); tick();
    #1;
    checks++;
    if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_read_during_rst: rdata1=%h rdata2=%h want 0", rdata1, rdata2);
    end
    rst = 1'b0;
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a); #1;
      checks++;
      if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg_x%0d: rdata1=%h rdata2=%h want 0", a, rdata1, rdata2);
      end
    end
    checks++;
    if (commit_cnt !== 32'd0 || wb_wreg !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: cnt=%h wreg=%b wd=%0d wdata=%h want all 0",
               commit_cnt, wb_wreg, wb_wd, wb_wdata);
    end
  endtask

  task automatic test_write_readback();
    idle(); wd = 5'd5; wreg = 1'b1; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd5;
    tick();
    idle(); #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL readback_bypass: rdata1=%h want deadbeef", rdata1);
    end
    checks++;
    if (wb_wd !== 5'd5 || wb_wreg !== 1'b1 || wb_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL readback_latch: wd=%0d wreg=%b wdata=%h want 5/1/deadbeef",
               wb_wd, wb_wreg, wb_wdata);
    end
    tick(); #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF || commit_cnt !== 32'd1) begin
      failures++;
      $display("FAIL readback_array: rdata1=%h cnt=%0d want deadbeef/1", rdata1, commit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0;
    c0 = commit_cnt;
    re2 = 1'b1; raddr2 = 5'd7;
    idle(); wd = 5'd7; wreg = 1'b1; wdata = 32'h1;
    tick();
    wdata = 32'h2; #1;
    checks++;
    if (rdata2 !== 32'h1) begin
      failures++;
      $display("FAIL b2b_first: rdata2=%h want 1", rdata2);
    end
    tick();
    idle(); #1;
    checks++;
    if (rdata2 !== 32'h2) begin
      failures++;
      $display("FAIL b2b_second_bypass: rdata2=%h want 2", rdata2);
    end
    tick(); #1;
    checks++;
    if (rdata2 !== 32'h2 || commit_cnt !== c0 + 32'd2) begin
      failures++;
      $display("FAIL b2b_settled: rdata2=%h cnt=%0d want 2/%0d", rdata2, commit_cnt, c0 + 32'd2);
    end
  endtask

  task automatic test_x0_and_disabled();
    logic [31:0] c0;
    c0 = commit_cnt;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    idle(); wd = 5'd0; wreg = 1'b1; wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
        failures++;
        $display("FAIL x0_read_cycle%0d: rdata1=%h rdata2=%h want 0", i, rdata1, rdata2);
      end
      tick();
      idle();
    end
    checks++;
    if (commit_cnt !== c0) begin
      failures++;
      $display("FAIL x0_not_counted: cnt=%0d want %0d", commit_cnt, c0);
    end
    re1 = 1'b0; raddr1 = 5'd5; #1;
    checks++;
    if (rdata1 !== 32'd0) begin
      failures++;
      $display("FAIL read_disabled: rdata1=%h want 0", rdata1);
    end
    re1 = 1'b1; #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_enabled_x5: rdata1=%h want deadbeef", rdata1);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] old9, v10, c0;
    for (int mode = 1; mode <= 3; mode++) begin
      old9 = arch[9];
      v10 = $urandom;
      idle(); wd = 5'd10; wreg = 1'b1; wdata = v10;
      tick();
      c0 = commit_cnt;
      idle(); wd = 5'd9; wreg = 1'b1; wdata = 32'h55 + 32'(mode);
      stall = mode[0]; flush = mode[1];
      tick();
      idle();
      re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd10; #1;
      checks++;
      if (wb_wreg !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 32'd0) begin
        failures++;
        $display("FAIL bubble_mode%0d: wreg=%b wd=%0d wdata=%h want 0/0/0",
                 mode, wb_wreg, wb_wd, wb_wdata);
      end
      checks++;
      if (rdata1 !== old9) begin
        failures++;
        $display("FAIL stall_keeps_x9_mode%0d: rdata1=%h want %h", mode, rdata1, old9);
      end
      checks++;
      if (rdata2 !== v10 || commit_cnt !== c0 + 32'd1) begin
        failures++;
        $display("FAIL prior_write_retires_mode%0d: x10=%h cnt=%0d want %h/%0d",
                 mode, rdata2, commit_cnt, v10, c0 + 32'd1);
      end
      tick(); #1;
      checks++;
      if (rdata1 !== old9) begin
        failures++;
        $display("FAIL stall_x9_later_mode%0d: rdata1=%h want %h", mode, rdata1, old9);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    idle(); wd = 5'd3; wreg = 1'b1; wdata = 32'hAA;
    tick();
    idle(); rst = 1'b1; re1 = 1'b1; raddr1 = 5'd3; #1;
    checks++;
    if (rdata1 !== 32'd0) begin
      failures++;
      $display("FAIL rst_forces_read0: rdata1=%h want 0", rdata1);
    end
    tick();
    rst = 1'b0; #1;
    checks++;
    if (rdata1 !== 32'd0 || commit_cnt !== 32'd0 || wb_wreg !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_write: x3=%h cnt=%0d wreg=%b want 0/0/0", rdata1, commit_cnt, wb_wreg);
    end
    tick(); #1;
    checks++;
    if (rdata1 !== 32'd0 || commit_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_write_after: x3=%h cnt=%0d want 0/0", rdata1, commit_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      wd    = 5'($urandom_range(0, 7));
      wreg  = ($urandom_range(0, 3) != 0);
      wdata = $urandom;
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      re1 = ($urandom_range(0, 7) != 0); raddr1 = 5'($urandom_range(0, 7));
      re2 = ($urandom_range(0, 7) != 0); raddr2 = 5'($urandom_range(0, 7));
      #1;
      e1 = expect_read(re1, raddr1);
      e2 = expect_read(re2, raddr2);
      checks++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        failures++;
        $display("FAIL rand_read_%0d: r1[%0d]=%h want %h r2[%0d]=%h want %h",
                 n, raddr1, rdata1, e1, raddr2, rdata2, e2);
      end
      checks++;
      if (wb_wd !== m_wd || wb_wreg !== m_wreg || wb_wdata !== m_wdata || commit_cnt !== m_cnt) begin
        failures++;
        $display("FAIL rand_state_%0d: wd=%0d wreg=%b wdata=%h cnt=%0d want %0d/%b/%h/%0d",
                 n, wb_wd, wb_wreg, wb_wdata, commit_cnt, m_wd, m_wreg, m_wdata, m_cnt);
      end
      tick();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    m_cnt = 32'd0; m_pend = 1'b0; m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    rst = 1'b1; idle();
    #2;
    test_reset();
    test_write_readback();
    test_back_to_back();
    test_x0_and_disabled();
    test_stall_flush();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
